// File: rtl/mc_pad_pkg.sv
// Shared pad-bank types: per-channel drive mode and default bank sizing.
package mc_pad_pkg;

  typedef enum logic [1:0] {
    ModeOff = 2'd0,
    ModeIn  = 2'd1,
    ModeOut = 2'd2,
    ModeOd  = 2'd3
  } pad_mode_e;

  localparam int unsigned NumPadsDefault   = 8;
  localparam int unsigned DebounceWDefault = 8;

endpackage

// File: rtl/mc_pad_bank_ctrl_if.sv
// Bundle of the core-side and pad-side signals of one pad bank.
interface mc_pad_bank_ctrl_if
  import mc_pad_pkg::*;
#(
  parameter int unsigned NumPads   = NumPadsDefault,
  parameter int unsigned DebounceW = DebounceWDefault
);

  pad_mode_e [NumPads-1:0] cfg_mode_i;
  logic [DebounceW-1:0]    cfg_debounce_i;
  logic [NumPads-1:0]      gpio_d_i;
  logic [NumPads-1:0]      gpio_d_o;
  logic [NumPads-1:0]      irq_rise_o;
  logic [NumPads-1:0]      irq_fall_o;
  logic [NumPads-1:0]      pad_d_o;
  logic [NumPads-1:0]      pad_oe_o;
  logic [NumPads-1:0]      pad_d_i;

  // Master is the core/pad-frame side driving the bank; slave is the bank itself.
  modport master (
    output cfg_mode_i, cfg_debounce_i, gpio_d_i, pad_d_i,
    input  gpio_d_o, irq_rise_o, irq_fall_o, pad_d_o, pad_oe_o
  );

  modport slave (
    input  cfg_mode_i, cfg_debounce_i, gpio_d_i, pad_d_i,
    output gpio_d_o, irq_rise_o, irq_fall_o, pad_d_o, pad_oe_o
  );

endinterface

// File: rtl/mc_pad_filter.sv
// One pad channel input path: 2-flop synchronizer, debounce counter and
// registered edge flags.
module mc_pad_filter #(
  parameter int unsigned DebounceW = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 en_i,
  input  logic [DebounceW-1:0] thresh_i,
  input  logic                 pad_i,
  output logic                 filt_o,
  output logic                 rise_o,
  output logic                 fall_o
);

  logic [1:0]           sync_q;
  logic                 filt_q, filt_d;
  logic [DebounceW-1:0] cnt_q, cnt_d;
  logic                 rise_q, rise_d;
  logic                 fall_q, fall_d;

  always_comb begin
    filt_d = filt_q;
    cnt_d  = cnt_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (!en_i) begin
      cnt_d = '0;
    end else if (sync_q[1] == filt_q) begin
      cnt_d = '0;
    end else if (cnt_q >= thresh_i) begin
      // >= so a threshold lowered below an in-progress count fires at once
      filt_d = sync_q[1];
      cnt_d  = '0;
      rise_d = sync_q[1];
      fall_d = ~sync_q[1];
    end else begin
      cnt_d = cnt_q + DebounceW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync_q <= '0;
      filt_q <= 1'b0;
      cnt_q  <= '0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], pad_i};
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign filt_o = filt_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/mc_pad_bank_ctrl.sv
// Pad bank controller: per-channel input filtering plus registered output
// drive decode toward the pad frame.
module mc_pad_bank_ctrl
  import mc_pad_pkg::*;
#(
  parameter int unsigned NumPads   = NumPadsDefault,
  parameter int unsigned DebounceW = DebounceWDefault
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  pad_mode_e [NumPads-1:0] cfg_mode_i,
  input  logic [DebounceW-1:0]    cfg_debounce_i,
  input  logic [NumPads-1:0]      gpio_d_i,
  output logic [NumPads-1:0]      gpio_d_o,
  output logic [NumPads-1:0]      irq_rise_o,
  output logic [NumPads-1:0]      irq_fall_o,
  output logic [NumPads-1:0]      pad_d_o,
  output logic [NumPads-1:0]      pad_oe_o,
  input  logic [NumPads-1:0]      pad_d_i
);

  logic [NumPads-1:0] pad_d_d, pad_d_q;
  logic [NumPads-1:0] pad_oe_d, pad_oe_q;

  for (genvar i = 0; i < NumPads; i++) begin : g_chan
    mc_pad_filter #(
      .DebounceW(DebounceW)
    ) u_filter (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .en_i    (cfg_mode_i[i] != ModeOff),
      .thresh_i(cfg_debounce_i),
      .pad_i   (pad_d_i[i]),
      .filt_o  (gpio_d_o[i]),
      .rise_o  (irq_rise_o[i]),
      .fall_o  (irq_fall_o[i])
    );
  end

  always_comb begin
    pad_d_d  = '0;
    pad_oe_d = '0;
    for (int i = 0; i < NumPads; i++) begin
      case (cfg_mode_i[i])
        ModeOut: begin
          pad_oe_d[i] = 1'b1;
          pad_d_d[i]  = gpio_d_i[i];
        end
        // Open drain: only ever pull low, release for a 1
        ModeOd:  pad_oe_d[i] = ~gpio_d_i[i];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pad_d_q  <= '0;
      pad_oe_q <= '0;
    end else begin
      pad_d_q  <= pad_d_d;
      pad_oe_q <= pad_oe_d;
    end
  end

  assign pad_d_o  = pad_d_q;
  assign pad_oe_o = pad_oe_q;

endmodule

// File: tb/tb_mc_pad_bank_ctrl.sv
// Directed self-checking bench for mc_pad_bank_ctrl with a 64-channel bank.
module tb_mc_pad_bank_ctrl;
  import mc_pad_pkg::*;

  localparam int unsigned N = 64;
  localparam int unsigned W = 8;
  localparam logic [N-1:0] Ones = '1;
  localparam logic [N-1:0] Zero = '0;
  localparam logic [N-1:0] Pat5 = 64'h5555_5555_5555_5555;
  localparam logic [N-1:0] PatA = 64'hAAAA_AAAA_AAAA_AAAA;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  mc_pad_bank_ctrl_if #(.NumPads(N), .DebounceW(W)) bus ();

  mc_pad_bank_ctrl #(
    .NumPads  (N),
    .DebounceW(W)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .cfg_mode_i    (bus.cfg_mode_i),
    .cfg_debounce_i(bus.cfg_debounce_i),
    .gpio_d_i      (bus.gpio_d_i),
    .gpio_d_o      (bus.gpio_d_o),
    .irq_rise_o    (bus.irq_rise_o),
    .irq_fall_o    (bus.irq_fall_o),
    .pad_d_o       (bus.pad_d_o),
    .pad_oe_o      (bus.pad_oe_o),
    .pad_d_i       (bus.pad_d_i)
  );

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_mode(input pad_mode_e m);
    for (int i = 0; i < N; i++) bus.cfg_mode_i[i] = m;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    set_mode(ModeIn);
    bus.cfg_debounce_i = '0;
    bus.gpio_d_i = Ones;
    bus.pad_d_i = Ones;
    for (int c = 0; c < 2; c++) begin
      cyc(1);
      n_cmp++;
      if ({bus.gpio_d_o, bus.irq_rise_o, bus.irq_fall_o, bus.pad_d_o, bus.pad_oe_o} !== '0) begin
        n_fail++;
        $display("FAIL reset_outputs: gpio=%h rise=%h fall=%h pd=%h oe=%h, required all 0",
                 bus.gpio_d_o, bus.irq_rise_o, bus.irq_fall_o, bus.pad_d_o, bus.pad_oe_o);
      end
    end
    rst_n = 1'b1;
    cyc(2);
    n_cmp++;
    if (bus.gpio_d_o !== Zero) begin
      n_fail++;
      $display("FAIL reset_early_gpio: got %h required %h", bus.gpio_d_o, Zero);
    end
    cyc(1);
    n_cmp++;
    if (bus.gpio_d_o !== Ones || bus.irq_rise_o !== Ones || bus.irq_fall_o !== Zero) begin
      n_fail++;
      $display("FAIL reset_release_rise: gpio=%h rise=%h fall=%h, required %h %h %h",
               bus.gpio_d_o, bus.irq_rise_o, bus.irq_fall_o, Ones, Ones, Zero);
    end
    cyc(1);
    n_cmp++;
    if (bus.irq_rise_o !== Zero) begin
      n_fail++;
      $display("FAIL reset_rise_single: got %h required %h", bus.irq_rise_o, Zero);
    end
  endtask

  task automatic test_glitch;
    bus.pad_d_i = Zero;
    cyc(5);
    n_cmp++;
    if (bus.gpio_d_o !== Zero) begin
      n_fail++;
      $display("FAIL glitch_settle: got %h required %h", bus.gpio_d_o, Zero);
    end
    bus.cfg_debounce_i = W'(5);
    bus.pad_d_i = Ones;
    cyc(4);
    bus.pad_d_i = Zero;
    for (int c = 0; c < 12; c++) begin
      cyc(1);
      n_cmp++;
      if (bus.gpio_d_o !== Zero || bus.irq_rise_o !== Zero || bus.irq_fall_o !== Zero) begin
        n_fail++;
        $display("FAIL glitch_reject c%0d: gpio=%h rise=%h fall=%h, required all 0",
                 c, bus.gpio_d_o, bus.irq_rise_o, bus.irq_fall_o);
      end
    end
    bus.pad_d_i = Ones;
    cyc(7);
    n_cmp++;
    if (bus.gpio_d_o !== Zero || bus.irq_rise_o !== Zero) begin
      n_fail++;
      $display("FAIL glitch_cycle7: gpio=%h rise=%h, required 0 0", bus.gpio_d_o, bus.irq_rise_o);
    end
    cyc(1);
    n_cmp++;
    if (bus.gpio_d_o !== Ones || bus.irq_rise_o !== Ones) begin
      n_fail++;
      $display("FAIL glitch_cycle8: gpio=%h rise=%h, required %h %h",
               bus.gpio_d_o, bus.irq_rise_o, Ones, Ones);
    end
    cyc(1);
    n_cmp++;
    if (bus.gpio_d_o !== Ones || bus.irq_rise_o !== Zero) begin
      n_fail++;
      $display("FAIL glitch_cycle9: gpio=%h rise=%h, required %h 0", bus.gpio_d_o,
               bus.irq_rise_o, Ones);
    end
  endtask

  task automatic test_output_modes;
    bus.gpio_d_i = Ones;
    set_mode(ModeOut);
    cyc(1);
    n_cmp++;
    if (bus.pad_oe_o !== Ones || bus.pad_d_o !== Ones) begin
      n_fail++;
      $display("FAIL mode_out: oe=%h d=%h required %h %h", bus.pad_oe_o, bus.pad_d_o, Ones, Ones);
    end
    set_mode(ModeOd);
    cyc(1);
    n_cmp++;
    if (bus.pad_oe_o !== Zero || bus.pad_d_o !== Zero) begin
      n_fail++;
      $display("FAIL mode_od_hi: oe=%h d=%h required 0 0", bus.pad_oe_o, bus.pad_d_o);
    end
    set_mode(ModeIn);
    cyc(1);
    n_cmp++;
    if (bus.pad_oe_o !== Zero || bus.pad_d_o !== Zero) begin
      n_fail++;
      $display("FAIL mode_in: oe=%h d=%h required 0 0", bus.pad_oe_o, bus.pad_d_o);
    end
    bus.gpio_d_i = Zero;
    set_mode(ModeOd);
    cyc(1);
    n_cmp++;
    if (bus.pad_oe_o !== Ones || bus.pad_d_o !== Zero) begin
      n_fail++;
      $display("FAIL mode_od_lo: oe=%h d=%h required %h 0", bus.pad_oe_o, bus.pad_d_o, Ones);
    end
    // Channel i uses mode i%4: OFF, IN, OUT, OD repeating
    for (int i = 0; i < N; i++) bus.cfg_mode_i[i] = pad_mode_e'(2'(i % 4));
    bus.gpio_d_i = 64'hCCCC_CCCC_CCCC_CCCC;
    cyc(1);
    n_cmp++;
    if (bus.pad_oe_o !== 64'h4444_4444_4444_4444 || bus.pad_d_o !== 64'h4444_4444_4444_4444) begin
      n_fail++;
      $display("FAIL mode_mixed_c: oe=%h d=%h required 4444.. 4444..", bus.pad_oe_o, bus.pad_d_o);
    end
    bus.gpio_d_i = 64'h3333_3333_3333_3333;
    cyc(1);
    n_cmp++;
    if (bus.pad_oe_o !== 64'hCCCC_CCCC_CCCC_CCCC || bus.pad_d_o !== Zero) begin
      n_fail++;
      $display("FAIL mode_mixed_3: oe=%h d=%h required cccc.. 0", bus.pad_oe_o, bus.pad_d_o);
    end
    set_mode(ModeIn);
    bus.gpio_d_i = Zero;
    cyc(1);
  endtask

  task automatic test_off_freeze;
    bus.cfg_debounce_i = '0;
    set_mode(ModeOff);
    bus.pad_d_i = Zero;
    for (int c = 0; c < 20; c++) begin
      cyc(1);
      n_cmp++;
      if (bus.gpio_d_o !== Ones || bus.irq_fall_o !== Zero || bus.irq_rise_o !== Zero) begin
        n_fail++;
        $display("FAIL off_freeze c%0d: gpio=%h fall=%h rise=%h, required %h 0 0",
                 c, bus.gpio_d_o, bus.irq_fall_o, bus.irq_rise_o, Ones);
      end
    end
    set_mode(ModeIn);
    cyc(1);
    n_cmp++;
    if (bus.gpio_d_o !== Zero || bus.irq_fall_o !== Ones) begin
      n_fail++;
      $display("FAIL off_resume: gpio=%h fall=%h required 0 %h", bus.gpio_d_o, bus.irq_fall_o, Ones);
    end
    cyc(1);
    n_cmp++;
    if (bus.irq_fall_o !== Zero) begin
      n_fail++;
      $display("FAIL off_resume_single: fall=%h required 0", bus.irq_fall_o);
    end
  endtask

  task automatic test_simultaneous;
    bus.pad_d_i = Ones;
    cyc(2);
    n_cmp++;
    if (bus.irq_rise_o !== Zero) begin
      n_fail++;
      $display("FAIL simul_early: rise=%h required 0", bus.irq_rise_o);
    end
    cyc(1);
    n_cmp++;
    if (bus.irq_rise_o !== Ones || bus.irq_fall_o !== Zero) begin
      n_fail++;
      $display("FAIL simul_rise: rise=%h fall=%h required %h 0", bus.irq_rise_o,
               bus.irq_fall_o, Ones);
    end
    bus.pad_d_i = Zero;
    cyc(3);
    n_cmp++;
    if (bus.irq_fall_o !== Ones || bus.irq_rise_o !== Zero) begin
      n_fail++;
      $display("FAIL simul_fall: fall=%h rise=%h required %h 0", bus.irq_fall_o,
               bus.irq_rise_o, Ones);
    end
    bus.pad_d_i = Pat5;
    cyc(3);
    n_cmp++;
    if (bus.irq_rise_o !== Pat5 || bus.irq_fall_o !== Zero || bus.gpio_d_o !== Pat5) begin
      n_fail++;
      $display("FAIL simul_pat5: rise=%h fall=%h gpio=%h required %h 0 %h",
               bus.irq_rise_o, bus.irq_fall_o, bus.gpio_d_o, Pat5, Pat5);
    end
    bus.pad_d_i = PatA;
    cyc(3);
    n_cmp++;
    if (bus.irq_rise_o !== PatA || bus.irq_fall_o !== Pat5 || bus.gpio_d_o !== PatA) begin
      n_fail++;
      $display("FAIL simul_patA: rise=%h fall=%h gpio=%h required %h %h %h",
               bus.irq_rise_o, bus.irq_fall_o, bus.gpio_d_o, PatA, Pat5, PatA);
    end
  endtask

  task automatic test_reset_mid;
    bus.pad_d_i = Zero;
    cyc(4);
    set_mode(ModeOut);
    bus.gpio_d_i = Ones;
    bus.cfg_debounce_i = W'(10);
    bus.pad_d_i = Ones;
    cyc(8);
    n_cmp++;
    if (bus.gpio_d_o !== Zero || bus.pad_oe_o !== Ones) begin
      n_fail++;
      $display("FAIL rmid_pre: gpio=%h oe=%h required 0 %h", bus.gpio_d_o, bus.pad_oe_o, Ones);
    end
    rst_n = 1'b0;
    cyc(1);
    n_cmp++;
    if ({bus.gpio_d_o, bus.irq_rise_o, bus.irq_fall_o, bus.pad_d_o, bus.pad_oe_o} !== '0) begin
      n_fail++;
      $display("FAIL rmid_reset: gpio=%h rise=%h pd=%h oe=%h, required all 0",
               bus.gpio_d_o, bus.irq_rise_o, bus.pad_d_o, bus.pad_oe_o);
    end
    rst_n = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      cyc(1);
      n_cmp++;
      if (bus.gpio_d_o !== Zero || bus.irq_rise_o !== Zero) begin
        n_fail++;
        $display("FAIL rmid_recount c%0d: gpio=%h rise=%h required 0 0",
                 c, bus.gpio_d_o, bus.irq_rise_o);
      end
    end
    cyc(1);
    n_cmp++;
    if (bus.gpio_d_o !== Ones || bus.irq_rise_o !== Ones) begin
      n_fail++;
      $display("FAIL rmid_rise: gpio=%h rise=%h required %h %h", bus.gpio_d_o,
               bus.irq_rise_o, Ones, Ones);
    end
  endtask

  task automatic test_threshold_change;
    bus.cfg_debounce_i = W'(20);
    bus.pad_d_i = Zero;
    cyc(9);
    n_cmp++;
    if (bus.gpio_d_o !== Ones || bus.irq_fall_o !== Zero) begin
      n_fail++;
      $display("FAIL thr_pending: gpio=%h fall=%h required %h 0", bus.gpio_d_o,
               bus.irq_fall_o, Ones);
    end
    // Count is 7 now; dropping the threshold below it must fire next edge
    bus.cfg_debounce_i = W'(3);
    cyc(1);
    n_cmp++;
    if (bus.gpio_d_o !== Zero || bus.irq_fall_o !== Ones) begin
      n_fail++;
      $display("FAIL thr_lowered: gpio=%h fall=%h required 0 %h", bus.gpio_d_o,
               bus.irq_fall_o, Ones);
    end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_output_modes();
    test_off_freeze();
    test_simultaneous();
    test_reset_mid();
    test_threshold_change();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mc_pad_bank_ctrl.md
MC_PAD_BANK_CTRL -- requirements
Module: mc_pad_bank_ctrl

Interface
REQ-001 SHALL have parameter NumPads, default 8: number of bidirectional pad channels, range 1..64.
REQ-002 SHALL have parameter DebounceW, default 8: width of the debounce threshold and of each per-channel counter.
REQ-003 SHALL have port clk_i, input, 1: single clock; all state is updated on its rising edge.
REQ-004 SHALL have port rst_ni, input, 1: reset, synchronous and active-low.
REQ-005 SHALL have port cfg_mode_i, input, NumPads x pad_mode_e (2 bits): per-channel mode, one of OFF=0, IN=1, OUT=2, OD=3.
REQ-006 SHALL have port cfg_debounce_i, input, DebounceW: debounce threshold, shared by all channels.
REQ-007 SHALL have port gpio_d_i, input, NumPads: core output data.
REQ-008 SHALL have port gpio_d_o, output, NumPads: filtered pad input value to the core.
REQ-009 SHALL have port irq_rise_o, input-edge flags, output, NumPads: single-cycle pulse on a 0->1 transition of gpio_d_o.
REQ-010 SHALL have port irq_fall_o, output, NumPads: single-cycle pulse on a 1->0 transition of gpio_d_o.
REQ-011 SHALL have port pad_d_o, output, NumPads: drive data to the pad cell d_i.
REQ-012 SHALL have port pad_oe_o, output, NumPads: output enable to the pad cell oe_i, active-high.
REQ-013 SHALL have port pad_d_i, input, NumPads: raw pad cell d_o, asynchronous to clk_i.

Function
REQ-014 SHALL pass pad_d_i through a two-flop synchronizer per channel, giving sync[i].
REQ-015 SHALL hold a per-channel filtered bit filt[i] and counter cnt[i].
- filt[i] drives gpio_d_o[i].
- Each cycle in IN, OUT or OD mode:
  - if sync==filt: cnt<=0.
  - else if cnt==cfg_debounce_i: filt<=sync, cnt<=0.
  - else: cnt<=cnt+1.
REQ-016 SHALL, with cfg_debounce_i=0, update filt one cycle after sync changes, giving 3 cycles total latency from pad_d_i to gpio_d_o.
REQ-017 SHALL, in general, apply total latency 3+cfg_debounce_i cycles for a stable input change.
- A pulse that reverts before the threshold is reached SHALL be rejected.
- The counter SHALL saturate: it never wraps, because it is cleared at the threshold.
REQ-018 SHALL assert irq_rise_o[i] or irq_fall_o[i] for exactly the one cycle following the filt[i] update.
- The pulse is registered.
- The two flags are never asserted together.
REQ-019 SHALL produce registered pad outputs, one cycle after cfg_mode_i and gpio_d_i:
- OFF: oe=0, d=0.
- IN: oe=0, d=0.
- OUT: oe=1, d=gpio_d_i.
- OD: d=0, oe=~gpio_d_i.
REQ-020 SHALL, in OFF mode, do the following:
- freeze filt[i];
- clear cnt[i];
- suppress both irq flags.
The synchronizer keeps running.
REQ-021 SHALL, on a mode change, apply the following:
- the new pad drive takes effect on the next cycle;
- filter state is kept, except cnt is cleared when entering OFF;
- the threshold change applies immediately to in-progress counts, and cnt>threshold SHALL be treated as reaching the threshold.
REQ-022 SHALL keep channels fully independent: no cross-channel state, and simultaneous events on all channels are each reported.

Reset
REQ-023 SHALL, while rst_ni=0 at a clock edge, clear the following to 0:
- the synchronizer flops;
- filt;
- cnt;
- irq_rise_o and irq_fall_o;
- pad_d_o, pad_oe_o and gpio_d_o.
REQ-024 SHALL, on reset asserted mid-debounce, discard the pending count; no irq is emitted for the aborted transition.
REQ-025 SHALL, if the pad is high after reset release in a non-OFF mode, report a rising edge via the normal filter path: filt starts at 0, so irq_rise_o pulses after 3+cfg_debounce_i cycles.

Structure
REQ-026 SHALL take the pad_mode_e enum (OFF/IN/OUT/OD) from shared package mc_pad_pkg, which also holds the default parameter constants.
REQ-027 SHALL instantiate one sub-module per channel, mc_pad_filter (synchronizer, debounce counter, edge flags), generated NumPads times.
REQ-028 SHALL keep the output mode decode in the top level, with no pad cell instances inside; pad cells are instantiated in the pad frame.

Verification
REQ-029 SHALL cover reset and idle:
- Stimulus: rst_ni=0 for 2 cycles, with pad_d_i all 1 and mode IN.
- Required response: all outputs 0 during reset; after release with debounce=0, gpio_d_o=all 1 and irq_rise_o=all 1 on cycle 3, then 0.
REQ-030 SHALL cover glitch rejection:
- Stimulus: debounce=5, pad 0->1 held for 4 cycles then back to 0.
- Required response: gpio_d_o stays 0 and no irq.
- Follow-up: held 1 for 10 cycles -> gpio_d_o rises at cycle 8 with a single irq_rise_o pulse.
REQ-031 SHALL cover output modes:
- Stimulus: gpio_d_i=1 with mode OUT, then OD, then IN.
- Required response (one cycle after each change): pad_oe_o/pad_d_o = 1/1, then 0/0, then 0/0.
- Follow-up: OD with gpio_d_i=0 -> oe=1, d=0.
REQ-032 SHALL cover OFF freeze:
- Stimulus: filt=1, set OFF, drive pad 0 for 20 cycles.
- Required response: gpio_d_o stays 1 and no irq_fall_o.
- Follow-up: return to IN with debounce=0 -> irq_fall_o pulses 1 cycle later.
REQ-033 SHALL cover simultaneous channels with NumPads=64:
- Stimulus: all pads toggle in the same cycle.
- Required response: all 64 irq flags pulse in the same cycle.
REQ-034 SHALL cover reset mid-debounce:
- Stimulus: debounce=10, apply reset at count 6.
- Required response: cnt=0, filt=0, and no irq afterwards for that edge until it is counted anew.
